// File: rtl/add_seq_ctrl_if.sv
// Request/response bundle for the nibble-serial adder controller.
// Master drives operands and handshakes; slave returns the registered result.
// Optional subtract select exists only when SUBTRACT_EN is defined.
interface add_seq_ctrl_if #(
    parameter int NIB = 4
);
    logic [4*NIB-1:0] a;
    logic [4*NIB-1:0] b;
    logic             cin;
    logic             in_vld;
    logic             in_rdy;
    logic             abort;
    logic [4*NIB-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_vld;
    logic             out_rdy;
`ifdef SUBTRACT_EN
    logic             sub;
`endif

    modport master (
        output a, b, cin, in_vld, abort, out_rdy,
`ifdef SUBTRACT_EN
        output sub,
`endif
        input  in_rdy, sum, cout, ovf, out_vld
    );

    modport slave (
        input  a, b, cin, in_vld, abort, out_rdy,
`ifdef SUBTRACT_EN
        input  sub,
`endif
        output in_rdy, sum, cout, ovf, out_vld
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// Nibble-serial A+B+Cin through one shared 4-bit ripple slice, LSB nibble first.
// Latency: accept at edge t, result valid after edge t+NIB; next accept at t+NIB+2 at the earliest.
// Backpressure: result held in DONE until out_rdy; abort returns to IDLE. Optional: SUBTRACT_EN adds sub.
module add_seq_ctrl #(
    parameter int NIB = 4
) (
    input logic          clk_i,
    input logic          rst_ni,
    add_seq_ctrl_if.slave bus
);
    localparam int W  = 4 * NIB;
    localparam int IW = $clog2(NIB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            cout_q;
    logic            ovf_q;
    logic            in_rdy_q;
    logic            out_vld_q;

    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [4:0]      slice_sum;
    logic [3:0]      low3_sum;
    logic [W-1:0]    b_cap_d;
    logic            carry_cap_d;

    // Shared 4-bit slice: pick the current nibble pair, add with carry, and
    // expose the carry into bit 3 for the signed-overflow test on the last nibble.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == IW'(n)) begin
                a_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end
        slice_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        low3_sum  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
    end

    // Operand B and initial carry as captured on accept (subtract inverts B, forces carry 1).
    always_comb begin
`ifdef SUBTRACT_EN
        b_cap_d     = bus.sub ? ~bus.b : bus.b;
        carry_cap_d = bus.sub ? 1'b1 : bus.cin;
`else
        b_cap_d     = bus.b;
        carry_cap_d = bus.cin;
`endif
    end

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // abort is meaningless here; an offered operation is taken regardless
                    if (bus.in_vld) begin
                        a_q      <= bus.a;
                        b_q      <= b_cap_d;
                        carry_q  <= carry_cap_d;
                        sum_q    <= '0;
                        idx_q    <= '0;
                        in_rdy_q <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        // partial sum is left as-is
                        in_rdy_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        for (int n = 0; n < NIB; n++) begin
                            if (idx_q == IW'(n)) begin
                                sum_q[4*n +: 4] <= slice_sum[3:0];
                            end
                        end
                        carry_q <= slice_sum[4];
                        if (idx_q == LAST_IDX) begin
                            // index parks at the last nibble; no second pass
                            cout_q    <= slice_sum[4];
                            ovf_q     <= low3_sum[3] ^ slice_sum[4];
                            out_vld_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.abort || bus.out_rdy) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_vld_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.out_vld = out_vld_q;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl at NIB=4: vector table plus abort, hold,
// and mid-operation reset sequences.
module tb_add_seq_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_seq_ctrl_if #(.NIB(NIB)) bus ();

    add_seq_ctrl #(.NIB(NIB)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and wait for the result; returns the cycles to out_vld.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic ab, output int lat);
        @(negedge clk);
        bus.a      = a;
        bus.b      = b;
        bus.cin    = cin;
        bus.abort  = ab;
        bus.in_vld = 1'b1;
        chk("in_rdy_idle", {31'd0, bus.in_rdy}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
        bus.abort  = 1'b0;
        // scramble inputs after accept; they must not influence the result
        bus.a      = ~a;
        bus.b      = a ^ b ^ 16'h5A5A;
        bus.cin    = ~cin;
        chk("in_rdy_busy", {31'd0, bus.in_rdy}, 32'd0);
        lat = 0;
        while (!bus.out_vld && lat < 3 * NIB) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.out_rdy = 1'b0;
        chk("in_rdy_after_pop", {31'd0, bus.in_rdy}, 32'd1);
        chk("out_vld_after_pop", {31'd0, bus.out_vld}, 32'd0);
    endtask

    task automatic run_op(input vec_t v, input int hold, input logic ab);
        int lat;
        issue(v.a, v.b, v.cin, ab, lat);
        chk("latency", lat, NIB);
        chk("sum", {16'd0, bus.sum}, {16'd0, v.sum});
        chk("cout", {31'd0, bus.cout}, {31'd0, v.cout});
        chk("ovf", {31'd0, bus.ovf}, {31'd0, v.ovf});
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            bus.in_vld = 1'b1;
            bus.a      = 16'(k * 16'h1111);
            @(posedge clk);
            #1;
            chk("hold_vld", {31'd0, bus.out_vld}, 32'd1);
            chk("hold_rdy", {31'd0, bus.in_rdy}, 32'd0);
            chk("hold_res", {14'd0, bus.cout, bus.ovf, bus.sum}, {14'd0, v.cout, v.ovf, v.sum});
        end
        bus.in_vld = 1'b0;
        release_result();
    endtask

    initial begin
        int lat;
        vecs[0] = '{16'h0006, 16'h0004, 1'b0, 16'h000A, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        bus.a       = '0;
        bus.b       = '0;
        bus.cin     = 1'b0;
        bus.in_vld  = 1'b0;
        bus.abort   = 1'b0;
        bus.out_rdy = 1'b0;
`ifdef SUBTRACT_EN
        bus.sub     = 1'b0;
`endif

        #12;
        chk("rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
        chk("rst_out_vld", {31'd0, bus.out_vld}, 32'd0);
        chk("rst_res", {14'd0, bus.cout, bus.ovf, bus.sum}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], 0, 1'b0);
        end

        // held result for 10 cycles, then an immediate back-to-back op
        run_op(vecs[2], 10, 1'b0);
        run_op(vecs[4], 0, 1'b0);

        // abort alongside in_vld in IDLE must still accept
        run_op(vecs[7], 0, 1'b1);

        // abort during the second RUN cycle: nibble 0 written, nothing else
        @(negedge clk);
        bus.a = 16'h0006; bus.b = 16'h0004; bus.cin = 1'b0; bus.in_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_vld = 1'b0;
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
        chk("abort_sum", {16'd0, bus.sum}, 32'h000A);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_vld) lat++;
        end
        chk("abort_no_vld", lat, 0);
        run_op(vecs[1], 0, 1'b0);

        // abort in DONE wins over out_rdy and keeps the result registers
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
        chk("done_lat", lat, NIB);
        @(negedge clk);
        bus.abort = 1'b1; bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0; bus.out_rdy = 1'b0;
        chk("done_abort_vld", {31'd0, bus.out_vld}, 32'd0);
        chk("done_abort_rdy", {31'd0, bus.in_rdy}, 32'd1);
        chk("done_abort_sum", {16'd0, bus.sum}, 32'h5556);

        // reset pulsed mid-RUN clears everything without a clock edge
        @(negedge clk);
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0; bus.in_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
        chk("midrst_out_vld", {31'd0, bus.out_vld}, 32'd0);
        chk("midrst_res", {14'd0, bus.cout, bus.ovf, bus.sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(vecs[3], 0, 1'b0);

`ifdef SUBTRACT_EN
        @(negedge clk);
        bus.sub = 1'b1;
        run_op('{16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0}, 0, 1'b0);
        bus.sub = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
